// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped one-word-line cache controller over a byte-wide memory
// Optional hit/miss counters: define DM_CACHE_STATS_EN.
module dm_cache_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    output logic        cpu_ready,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        cpu_hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESP} state_t;

    state_t                  state, state_nx;
    logic [1:0]              cnt;
    logic [31:2]             addr_q;
    logic [31:0]             wdata_q;
    logic                    we_q;
    logic                    hit_q;
    logic [23:0]             fill_q;
    logic [LINES-1:0]        valid;
    logic [TAG_BITS-1:0]     tag_arr  [LINES];
    logic [31:0]             data_arr [LINES];

    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_BITS-1:0]     tag;
    logic                    lookup_hit;
    logic                    xfer;
    logic                    last_ack;
    logic [31:0]             fill_word;
    logic                    addr_lsb_unused;

    // Word-aligned requests only: the byte offset never reaches the arrays.
    assign addr_lsb_unused = ^cpu_addr[1:0];

    assign idx        = addr_q[INDEX_BITS+1:2];
    assign tag        = addr_q[31:INDEX_BITS+2];
    assign lookup_hit = valid[idx] && (tag_arr[idx] == tag);
    assign xfer       = (state == REFILL) || (state == WRITE);
    assign last_ack   = xfer && mem_ack && (cnt == 2'd3);
    assign fill_word  = {mem_rdata, fill_q};

    assign cpu_ready = (state == IDLE);
    assign cpu_done  = (state == RESP);
    assign cpu_hit   = hit_q;
    assign mem_req   = xfer;
    assign mem_we    = (state == WRITE);
    assign mem_addr  = {addr_q, cnt};

    always_comb begin
        mem_wdata = wdata_q[7:0];
        case (cnt)
            2'd1:    mem_wdata = wdata_q[15:8];
            2'd2:    mem_wdata = wdata_q[23:16];
            2'd3:    mem_wdata = wdata_q[31:24];
            default: mem_wdata = wdata_q[7:0];
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:          if (cpu_req) state_nx = LOOKUP;
            LOOKUP:        state_nx = we_q ? WRITE : (lookup_hit ? RESP : REFILL);
            REFILL, WRITE: if (mem_ack && cnt == 2'd3) state_nx = RESP;
            RESP:          state_nx = IDLE;
            default:       state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            hit_q     <= 1'b0;
            fill_q    <= '0;
            cpu_rdata <= '0;
            valid     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr[31:2];
                        wdata_q <= cpu_wdata;
                    end
                end
                LOOKUP: begin
                    hit_q <= lookup_hit;
                    cnt   <= 2'd0;
                    if (!we_q && lookup_hit) cpu_rdata <= data_arr[idx];
                end
                REFILL, WRITE: begin
                    if (mem_ack) begin
                        cnt <= cnt + 2'd1;
                        if (state == REFILL) begin
                            case (cnt)
                                2'd0:    fill_q[7:0]   <= mem_rdata;
                                2'd1:    fill_q[15:8]  <= mem_rdata;
                                2'd2:    fill_q[23:16] <= mem_rdata;
                                default: cpu_rdata     <= fill_word;
                            endcase
                        end
                        // Line becomes valid only once all four bytes have moved.
                        if (cnt == 2'd3) valid[idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (last_ack) begin
            tag_arr[idx]  <= tag;
            data_arr[idx] <= we_q ? wdata_q : fill_word;
        end
    end

`ifdef DM_CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == RESP) begin
            if (hit_q) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - scoreboard bench for dm_cache_ctrl with a byte-memory responder
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_ready;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_hit;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
`ifdef DM_CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    dm_cache_ctrl #(.INDEX_BITS(4), .TAG_BITS(26)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DM_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        bit          hit;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [7:0]  d;
    } bus_t;

    resp_t exp_q[$];
    bus_t  bus_q[$];

    // Reference: the memory as the CPU should see it, and the cache contents.
    logic [7:0]  mem_m [256];
    logic [7:0]  mem_p [256];
    bit          m_valid [16];
    int          m_tag [16];
    logic [31:0] m_data [16];
    int          m_hits = 0;
    int          m_misses = 0;
    int          wait_cyc = 0;
    int          bytes_acc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_req(input bit we, input logic [7:0] a, input logic [31:0] wd,
                             input int w, input int acc);
        int          idx;
        int          tg;
        int          base;
        bit          hit;
        logic [31:0] word;
        resp_t       r;
        idx  = (a / 4) % 16;
        tg   = a / 64;
        base = a - (a % 4);
        hit  = m_valid[idx] && (m_tag[idx] == tg);
        r.we = we; r.hit = hit; r.acc = acc; r.rdata = '0;
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                bus_q.push_back('{1'b1, 32'(base + k), wd[8*k +: 8]});
                mem_m[base + k] = wd[8*k +: 8];
            end
            m_data[idx] = wd;
            r.lat = 3 + 4 * (1 + w);
        end else if (hit) begin
            r.rdata = m_data[idx];
            r.lat = 3;
        end else begin
            word = '0;
            for (int k = 0; k < 4; k++) begin
                bus_q.push_back('{1'b0, 32'(base + k), 8'h00});
                word[8*k +: 8] = mem_m[base + k];
            end
            m_data[idx] = word;
            r.rdata = word;
            r.lat = 3 + 4 * (1 + w);
        end
        m_valid[idx] = 1'b1;
        m_tag[idx] = tg;
        if (hit) m_hits++; else m_misses++;
        exp_q.push_back(r);
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!cpu_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_timeout", {31'd0, cpu_ready}, 32'd1);
    endtask

    task automatic issue(input bit we, input logic [7:0] a, input logic [31:0] wd, input int w);
        wait_ready();
        wait_cyc = w;
        model_req(we, a, wd, w, cyc);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = {24'h0, a}; cpu_wdata = wd;
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
    endtask

    task automatic do_req(input bit we, input logic [7:0] a, input logic [31:0] wd, input int w);
        int t;
        issue(we, a, wd, w);
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("resp_timeout", exp_q.size(), 0);
            exp_q.delete();
            bus_q.delete();
        end
    endtask

    // Monitor: pops one expected response per completion pulse.
    always @(negedge clk) begin
        resp_t r;
        if (rst_n && cpu_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                r = exp_q.pop_front();
                chk("cpu_hit", {31'd0, cpu_hit}, {31'd0, r.hit});
                if (!r.we) chk("cpu_rdata", cpu_rdata, r.rdata);
                chk("latency", cyc - r.acc + 1, r.lat);
            end
        end
    end

    // Memory responder: acks at negedge, transfer counts as done at the following posedge.
    bit          pend = 0;
    bus_t        pend_t;
    bit          prev_wait = 0;
    logic [31:0] prev_a = '0;
    bit          prev_we = 0;
    int          wc = 0;

    always @(negedge clk) begin
        bus_t e;
        if (!rst_n) begin
            mem_ack = 1'b0; pend = 0; wc = 0; prev_wait = 0;
        end else begin
            if (pend) begin
                bytes_acc++;
                if (bus_q.size() == 0) begin
                    chk("spurious_mem_xfer", pend_t.a, 32'hFFFF_FFFF);
                end else begin
                    e = bus_q.pop_front();
                    chk("mem_we", {31'd0, pend_t.we}, {31'd0, e.we});
                    chk("mem_addr", pend_t.a, e.a);
                    if (e.we) chk("mem_wdata", {24'd0, pend_t.d}, {24'd0, e.d});
                end
                if (pend_t.we) mem_p[pend_t.a[7:0]] = pend_t.d;
            end
            pend = 0;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (prev_wait) begin
                    chk("wait_addr_stable", mem_addr, prev_a);
                    chk("wait_we_stable", {31'd0, mem_we}, {31'd0, prev_we});
                end
                if (wc < wait_cyc) begin
                    wc++;
                    prev_wait = 1;
                end else begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_p[mem_addr[7:0]];
                    pend = 1;
                    pend_t = '{mem_we, mem_addr, mem_wdata};
                    wc = 0;
                    prev_wait = 0;
                end
                prev_a = mem_addr;
                prev_we = mem_we;
            end else begin
                if (prev_wait) chk("wait_req_stable", 32'd0, 32'd1);
                prev_wait = 0;
                wc = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int t;
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = 8'($urandom);
            mem_p[i] = mem_m[i];
        end
        mem_m[12] = 8'h09; mem_m[13] = 8'h00; mem_m[14] = 8'h00; mem_m[15] = 8'h00;
        for (int i = 12; i < 16; i++) mem_p[i] = mem_m[i];
        for (int i = 0; i < 16; i++) m_valid[i] = 0;

        repeat (3) @(negedge clk);
        chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_cpu_done",  {31'd0, cpu_done},  32'd0);
        chk("rst_cpu_hit",   {31'd0, cpu_hit},   32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_mem_addr",  mem_addr, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        rst_n = 1'b1;

        do_req(1'b0, 8'h0C, 32'h0, 0);
        chk("tp_first_read", cpu_rdata, 32'h0000_0009);
        do_req(1'b0, 8'h0C, 32'h0, 0);
        do_req(1'b1, 8'h08, 32'h0000_000F, 0);
        do_req(1'b0, 8'h08, 32'h0, 0);
        chk("tp_write_readback", cpu_rdata, 32'h0000_000F);

        do_req(1'b0, 8'h04, 32'h0, 0);
        do_req(1'b0, 8'h44, 32'h0, 0);
        do_req(1'b0, 8'h04, 32'h0, 0);

        do_req(1'b0, 8'h80, 32'h0, 5);

        for (int n = 0; n < 80; n++)
            do_req(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), $urandom,
                   int'($urandom_range(0, 2)));

        // Reset during a refill after two bytes have been accepted.
        issue(1'b0, 8'h30, 32'h0, 0);
        start = bytes_acc - 0;
        t = 0;
        while (bytes_acc < start + 2 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("abort_bytes_seen", bytes_acc - start, 2);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req",   {31'd0, mem_req},   32'd0);
        chk("abort_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        chk("abort_cpu_done",  {31'd0, cpu_done},  32'd0);
        exp_q.delete();
        bus_q.delete();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_hits = 0;
        m_misses = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 8'h30, 32'h0, 0);
        do_req(1'b0, 8'h30, 32'h0, 1);

`ifdef DM_CACHE_STATS_EN
        @(negedge clk);
        chk("hit_count",  {16'd0, hit_count},  32'(m_hits));
        chk("miss_count", {16'd0, miss_count}, 32'(m_misses));
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Clocked controller for a direct-mapped, one-word-per-line cache in front of a byte-wide backing memory.
- Accepts one CPU word request at a time and performs the tag/valid lookup.
- Sequences the 4-byte refill on a read miss and the 4-byte write-through on every write, then returns data and a hit flag.
- Sits between the CPU load/store path and the byte-addressed main memory; owns the tag, valid and data arrays.

Parameters:
- INDEX_BITS, 4, index width; the cache holds 2**INDEX_BITS lines.
- TAG_BITS, 26, tag width; must equal 30-INDEX_BITS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  request valid.
- cpu_ready  out  1  controller idle; a request is accepted when cpu_req && cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  write data, little-endian.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data, valid while cpu_done=1 for reads.
- cpu_hit  out  1  line valid and tag matched at lookup; valid while cpu_done=1.
- mem_req  out  1  byte transfer request.
- mem_we  out  1  1 = byte write.
- mem_addr  out  32  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, sampled on the ack cycle.
- mem_ack  in  1  transfer complete this cycle; ignored while mem_req=0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all valid bits cleared.
  - state=IDLE; byte counter=0.
  - cpu_ready=1, cpu_done=0, cpu_hit=0, cpu_rdata=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-transfer aborts immediately. No partial line is marked valid.
- Address split: index=addr[INDEX_BITS+1:2], tag=addr[31:INDEX_BITS+2]. Byte k of the word is at {addr[31:2],k} and maps to data[8k+7:8k].
- States: IDLE, LOOKUP, REFILL, WRITE, RESP.
- IDLE:
  - cpu_ready=1.
  - On accept: register we, addr and wdata; go to LOOKUP. Later changes on CPU inputs are ignored.
- LOOKUP (cpu_ready=0):
  - hit = valid[index] && tag_arr[index]==tag. Register hit.
  - Read hit: latch data into cpu_rdata; go to RESP. Read latency is 3 cycles from the accept edge to cpu_done.
  - Read miss: go to REFILL, counter=0.
  - Write (hit or miss): go to WRITE, counter=0.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={addr[31:2],cnt}.
  - On mem_ack: store mem_rdata into byte cnt of the fill register; cnt++.
  - After the ack for cnt=3:
    - write the line data, tag_arr[index]=tag, valid[index]=1.
    - cpu_rdata=filled word; go to RESP.
  - mem_req stays high across back-to-back bytes. Wait states are unbounded.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr={addr[31:2],cnt}, mem_wdata=wdata byte cnt.
  - Advance on mem_ack as in REFILL.
  - After byte 3: line data=wdata, tag updated, valid=1 (write-allocate, write-through); go to RESP.
  - cpu_rdata is not updated on writes.
- RESP:
  - cpu_done=1 for exactly one cycle; cpu_hit=registered hit; go to IDLE.
  - cpu_ready returns to 1 the next cycle, so back-to-back requests are spaced at least 3 cycles apart.
- Conflict eviction: a miss to an occupied index overwrites the line. No dirty state exists because the cache is write-through.
- mem_req is 0 in IDLE, LOOKUP and RESP.
- Outputs are registered; no combinational path from cpu_* inputs to outputs.

Optional Feature:
- Macro: DM_CACHE_STATS_EN.
- When defined:
  - adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments by 1 in the cycle cpu_done pulses, according to cpu_hit, for reads and writes alike.
  - Both saturate at 16'hFFFF and reset to 0 asynchronously.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- After reset, read 0x0000_000C with memory bytes 0x09,0x00,0x00,0x00 at 0xC..0xF:
  - 4 mem reads at 0xC,0xD,0xE,0xF.
  - cpu_done with cpu_rdata=0x0000_0009, cpu_hit=0.
  - A repeat read gives cpu_hit=1, the same data, no mem_req, and cpu_done 3 cycles after accept.
- Write 0x0000_000F to 0x0000_0008:
  - mem writes 0x0F,0x00,0x00,0x00 at 0x8..0xB; cpu_hit=0.
  - A following read of 0x8 hits with 0x0000_000F.
- Conflict with INDEX_BITS=4: read 0x0000_0004, then 0x0000_0044 (same index 1, different tag), then 0x4 again.
  - Results are miss, miss, miss, and each access triggers a refill.
- Wait states: mem_ack held low 5 cycles per byte during a refill.
  - mem_req and mem_addr stay stable while waiting.
  - Data is correct; cpu_done is delayed by exactly 20 cycles versus zero-wait.
- Reset asserted after the second refill byte is acked:
  - mem_req drops immediately; cpu_ready=1.
  - A subsequent read of the same address misses.
- With DM_CACHE_STATS_EN defined, run scenario 1, then 1 write miss:
  - hit_count=1, miss_count=2.
  - With hit_count preloaded to 0xFFFF, it stays 0xFFFF after a further hit.
